// File: rtl/sisc_pkg.sv
// Shared SISC definitions: the arbiter state encoding, the requester port IDs
// and the default bus widths.
package sisc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_arb_rr_pick2.sv
// Two-way round-robin picker. It is purely combinational; the caller keeps the
// last-grant flop.
module rr_pick2
  import sisc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Grant the single requester, or on a tie the one that did not win last time.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = PORT_IF;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_id    = PORT_IF;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_id    = PORT_D;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_id    = ~last;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_id    = PORT_IF;
      end
    endcase
  end

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter that shares one memory port between instruction fetch
// and data accesses. Each access runs through grant, issue, a fixed wait, capture
// and a one-cycle acknowledge.
module mem_arb
  import sisc_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // The wait counter is loaded with MEM_LAT-2, so MEM_LAT=1 never uses it.
  localparam logic [1:0] CNT_LOAD = (MEM_LAT >= 2) ? 2'(MEM_LAT - 2) : 2'd0;

  arb_state_e    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          port_q, port_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          gnt_valid_s, gnt_id_s;

  rr_pick2 u_pick (
    .req       ({d_req, if_req}),
    .last      (last_q),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    port_d      = port_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_d  = ST_ISSUE;
          port_d   = gnt_id_s;
          last_d   = gnt_id_s;
          mem_en_d = 1'b1;
          if (gnt_id_s == PORT_D) begin
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            mem_wdata_d = d_wdata;
          end else begin
            mem_addr_d = if_addr;
            mem_we_d   = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (MEM_LAT == 1) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_DONE;
        // Writes leave both read-data registers untouched.
        if (!mem_we_q) begin
          if (port_q == PORT_D) begin
            d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
        end else begin
          d_rdata_d = d_rdata_q;
        end
        if (port_q == PORT_D) begin
          d_ack_d = 1'b1;
        end else begin
          if_ack_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      last_q      <= PORT_D;
      port_q      <= PORT_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      port_q      <= port_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: one instance with MEM_LAT=1 and one with MEM_LAT=3 are driven
// one at a time and checked against a transaction-level model and a memory model.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        if_req = 1'b0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] if_addr = 16'h0;
  logic [15:0] d_addr = 16'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] mem_rdata;
  int          sel = 0;
  int          lat_of [2] = '{1, 3};
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  ifq_g, dq_g, if_ack_w, d_ack_w, en_w, we_w, busy_w;
  logic [15:0] maddr_w [2];
  logic [31:0] mwd_w [2], ifr_w [2], dr_w [2];

  assign ifq_g = {if_req & (sel == 1), if_req & (sel == 0)};
  assign dq_g  = {d_req & (sel == 1), d_req & (sel == 0)};

  mem_arb #(.AW(16), .DW(32), .MEM_LAT(1)) u_l1 (
    .clk(clk), .rst_f(rst_f),
    .if_req(ifq_g[0]), .if_addr(if_addr), .if_ack(if_ack_w[0]), .if_rdata(ifr_w[0]),
    .d_req(dq_g[0]), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_w[0]), .d_rdata(dr_w[0]),
    .mem_en(en_w[0]), .mem_we(we_w[0]), .mem_addr(maddr_w[0]), .mem_wdata(mwd_w[0]),
    .mem_rdata(mem_rdata), .busy(busy_w[0])
  );

  mem_arb #(.AW(16), .DW(32), .MEM_LAT(3)) u_l3 (
    .clk(clk), .rst_f(rst_f),
    .if_req(ifq_g[1]), .if_addr(if_addr), .if_ack(if_ack_w[1]), .if_rdata(ifr_w[1]),
    .d_req(dq_g[1]), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_w[1]), .d_rdata(dr_w[1]),
    .mem_en(en_w[1]), .mem_we(we_w[1]), .mem_addr(maddr_w[1]), .mem_wdata(mwd_w[1]),
    .mem_rdata(mem_rdata), .busy(busy_w[1])
  );

  logic        c_en, c_we, c_ifack, c_dack, c_busy;
  logic [15:0] c_addr;
  logic [31:0] c_wd, c_ifr, c_dr;
  assign c_en    = en_w[sel];
  assign c_we    = we_w[sel];
  assign c_ifack = if_ack_w[sel];
  assign c_dack  = d_ack_w[sel];
  assign c_busy  = busy_w[sel];
  assign c_addr  = maddr_w[sel];
  assign c_wd    = mwd_w[sel];
  assign c_ifr   = ifr_w[sel];
  assign c_dr    = dr_w[sel];

  // Contents of never-written locations.
  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {a ^ 16'hC3C3, ~a};
  endfunction

  // Memory model: writes land on the strobe; read data is valid only in the
  // single cycle MEM_LAT after the strobe and is inverted (garbage) otherwise.
  logic [31:0] model_mem [int];
  int          rd_cnt = 0;
  logic [15:0] rd_addr = 16'h0;
  always @(negedge clk) begin
    logic [31:0] v;
    v = model_mem.exists(int'(rd_addr)) ? model_mem[int'(rd_addr)] : dflt(rd_addr);
    mem_rdata = (rd_cnt == 1) ? v : ~v;
    if (rd_cnt > 0) rd_cnt = rd_cnt - 1;
    if (!rst_f) begin
      rd_cnt = 0;
    end else if (c_en) begin
      if (c_we) model_mem[int'(c_addr)] = c_wd;
      else begin
        rd_cnt  = lat_of[sel];
        rd_addr = c_addr;
      end
    end
  end

  // Reference model state: expected memory, last winner and read-data registers.
  logic [31:0] ref_mem [int];
  logic        ref_last [2];
  logic [31:0] ref_ifr [2], ref_dr [2];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ref_last[k] = 1'b1;
      ref_ifr[k]  = 32'h0;
      ref_dr[k]   = 32'h0;
    end
  endtask

  // One access, started at a negedge while the selected arbiter is idle.
  task automatic txn(input logic ion, input logic don, input logic we,
                     input logic [15:0] ia, input logic [15:0] da, input logic [31:0] wd,
                     input bit drop, input bit hold,
                     output int ack_cyc, output logic ack_port);
    int          lat = lat_of[sel];
    logic        win;
    logic        exp_we;
    logic [15:0] a;
    logic [31:0] exp_rd;
    int en_n = 0, en_rel = -1, ack_n = 0, ack_rel = -1, both = 0;
    logic idle_after = 1'b0;
    ack_cyc  = -1;
    ack_port = 1'b0;
    if_req = ion; d_req = don; d_we = we; if_addr = ia; d_addr = da; d_wdata = wd;
    chk("busy_before_grant", c_busy, 0);
    win = (ion && don) ? ~ref_last[sel] : don;
    ref_last[sel] = win;
    a      = win ? da : ia;
    exp_we = win & we;
    if (exp_we) ref_mem[int'(a)] = wd;
    exp_rd = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    for (int rel = 1; rel <= 14; rel++) begin
      @(negedge clk);
      if (rel == 1 && drop) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      if (rel == 1) chk("busy_after_grant", c_busy, 1);
      if (c_en) begin
        en_n++;
        en_rel = rel;
        chk("issue_addr", c_addr, a);
        chk("issue_we", c_we, exp_we);
        if (exp_we) chk("issue_wdata", c_wd, wd);
      end
      if (rel == lat + 1) chk("resp_addr_stable", c_addr, a);
      if (c_ifack && c_dack) both++;
      if (c_ifack || c_dack) begin
        ack_n++;
        ack_rel  = rel;
        ack_port = c_dack;
        ack_cyc  = cyc;
        if (!hold) begin
          if_req = 1'b0;
          d_req  = 1'b0;
        end
      end
      if (ack_rel > 0 && rel == ack_rel + 1) begin
        idle_after = ~c_busy;
        break;
      end
    end
    chk("mem_en_count", en_n, 1);
    chk("mem_en_cycle", en_rel, 1);
    chk("ack_count", ack_n, 1);
    chk("ack_latency", ack_rel, lat + 2);
    chk("ack_port", ack_port, win);
    chk("acks_overlap", both, 0);
    chk("idle_after_done", idle_after, 1);
    if (!exp_we) begin
      if (win) ref_dr[sel] = exp_rd;
      else ref_ifr[sel] = exp_rd;
    end
    chk("if_rdata", c_ifr, ref_ifr[sel]);
    chk("d_rdata", c_dr, ref_dr[sel]);
  endtask

  initial begin
    int   a1, a2, a3, nacks;
    logic p1, p2, p3;
    logic [15:0] pool [4] = '{16'h0010, 16'h0042, 16'h0200, 16'h7FFE};

    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k;
      #1;
      chk("rst_busy", c_busy, 0);
      chk("rst_mem_en", c_en, 0);
      chk("rst_acks", {c_ifack, c_dack}, 0);
      chk("rst_if_rdata", c_ifr, 0);
      chk("rst_d_rdata", c_dr, 0);
    end
    sel = 0;
    rst_f = 1'b1;
    @(negedge clk);

    // Fetch only, MEM_LAT=1.
    model_mem[16'h0010] = 32'hA5A5_0001;
    ref_mem[16'h0010]   = 32'hA5A5_0001;
    txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 32'h0, 1'b0, 1'b0, a1, p1);
    chk("fetch_word", c_ifr, 32'hA5A5_0001);

    // Data write.
    txn(1'b0, 1'b1, 1'b1, 16'h0, 16'h0200, 32'h1234_5678, 1'b0, 1'b0, a1, p1);

    // Held tie: fetch, data, fetch, one access every 4 cycles.
    txn(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0200, 32'h0, 1'b0, 1'b1, a1, p1);
    txn(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0200, 32'h0, 1'b0, 1'b1, a2, p2);
    txn(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0200, 32'h0, 1'b0, 1'b1, a3, p3);
    chk("tie_order", {p1, p2, p3}, 3'b010);
    chk("tie_gap1", a2 - a1, 4);
    chk("tie_gap2", a3 - a2, 4);
    chk("readback_write", c_dr, 32'h1234_5678);
    if_req = 1'b0; d_req = 1'b0;

    // MEM_LAT=3 read and dropped request.
    sel = 1;
    txn(1'b0, 1'b1, 1'b0, 16'h0, 16'h0042, 32'h0, 1'b0, 1'b0, a1, p1);
    txn(1'b0, 1'b1, 1'b0, 16'h0, 16'h7FFE, 32'h0, 1'b1, 1'b0, a1, p1);
    sel = 0;
    txn(1'b1, 1'b0, 1'b0, 16'h0042, 16'h0, 32'h0, 1'b1, 1'b0, a1, p1);

    // Reset in the middle of WAIT on the MEM_LAT=3 instance.
    sel = 1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0123; d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_wait", c_busy, 1);
    rst_f = 1'b0;
    #1;
    chk("midrst_busy", c_busy, 0);
    chk("midrst_mem_en", c_en, 0);
    chk("midrst_mem_we", c_we, 0);
    chk("midrst_mem_addr", c_addr, 0);
    chk("midrst_mem_wdata", c_wd, 0);
    chk("midrst_acks", {c_ifack, c_dack}, 0);
    chk("midrst_if_rdata", c_ifr, 0);
    chk("midrst_d_rdata", c_dr, 0);
    d_req = 1'b0; d_we = 1'b0;
    model_reset();
    @(negedge clk);
    rst_f = 1'b1;
    nacks = 0;
    repeat (6) begin
      @(negedge clk);
      if (c_ifack || c_dack) nacks++;
    end
    chk("no_ack_after_reset", nacks, 0);
    txn(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0042, 32'h0, 1'b0, 1'b0, a1, p1);
    chk("tie_after_reset_fetch", p1, 0);

    // Randomised mix on both instances.
    for (int i = 0; i < 40; i++) begin
      int   mode;
      logic rw, dr;
      if_req = 1'b0; d_req = 1'b0;
      sel  = int'($urandom_range(0, 1));
      mode = int'($urandom_range(1, 3));
      rw   = 1'($urandom_range(0, 1));
      dr   = ($urandom_range(0, 3) == 0);
      txn(mode[0], mode[1], rw, pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
          $urandom, dr, 1'b0, a1, p1);
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
